ser_word_tx: RTL
================

// Module: ser_word_tx
// PURPOSE
//  Parallel-to-serial word transmitter. Accepts one WIDTH-bit word per valid/ready handshake.
//  Drives an internal Shiftreg primitive: load on accept, en once per bit period.
//  Emits a framed serial stream: ser_clk, ser_data and ser_frame.
//  Sits between a word source (FIFO/register file) and a board-level serial link.
// PARAMETERS
//  WIDTH      8  bits per word, >=2
//  DIRECTION  0  0 = LSB first (shift right), 1 = MSB first (shift left); passed to Shiftreg
//  CLK_DIV    4  clk cycles per serial bit, even, >=2 (elaboration $error otherwise)
// PORTS
//  clk        in   1      system clock, all logic on rising edge
//  clrn       in   1      asynchronous reset, active-low
//  sclr       in   1      synchronous clear, active-low; same effect as clrn, at the clk edge
//  tx_data    in   WIDTH  word to send; sampled when tx_valid & tx_ready
//  tx_valid   in   1      source has a word
//  tx_ready   out  1      block can accept a word (= state IDLE)
//  ser_clk    out  1      serial bit clock, registered
//  ser_data   out  1      serial data, = Shiftreg.shiftout while ser_frame, else 0
//  ser_frame  out  1      high for the whole word, registered
//  busy       out  1      state != IDLE
//  done       out  1      one-cycle pulse after the last bit period
// BEHAVIOUR
//  Reset (clrn low or sclr low at the edge): state IDLE, div_cnt=0, bit_cnt=0, Shiftreg cleared.
//   Outputs in reset: tx_ready=1, ser_clk=0, ser_data=0, ser_frame=0, busy=0, done=0.
//   Reset mid-word aborts the word immediately. No partial word resumes.
//  FSM IDLE -> SHIFT -> DONE -> IDLE (states in ser_pkg::tx_state_t).
//  IDLE: tx_ready=1. If tx_valid is high at an edge: Shiftreg load=en=1 (data=tx_data), div_cnt=0,
//   bit_cnt=0, go to SHIFT. Otherwise hold. tx_valid without tx_ready is ignored; no buffering.
//  SHIFT: div_cnt increments each clk and wraps at CLK_DIV-1.
//   ser_clk=0 while div_cnt<CLK_DIV/2, else 1. Data is stable across the rising ser_clk edge.
//   At div_cnt==CLK_DIV-1:
//    if bit_cnt==WIDTH-1 -> go to DONE, no shift
//    else Shiftreg en=1, load=0, shiftin=0; bit_cnt++
//  DONE: one cycle. done=1, ser_frame=0, ser_clk=0, tx_ready=0. Then go to IDLE.
//  Latency: accept at edge k -> ser_frame=1 and first bit on ser_data from cycle k+1.
//   SHIFT lasts WIDTH*CLK_DIV cycles. done pulses in cycle k+1+WIDTH*CLK_DIV.
//   tx_ready returns one cycle later.
//   Max throughput: one word per WIDTH*CLK_DIV+2 cycles.
//  Bit order: DIRECTION=0 sends tx_data[0] first; DIRECTION=1 sends tx_data[WIDTH-1] first.
//  Widths: bit_cnt is $clog2(WIDTH) bits; div_cnt is $clog2(CLK_DIV) bits; no overflow by construction.
//  tx_valid held high continuously: a new word is accepted on the first IDLE cycle after DONE.
// STRUCTURE
//  Package ser_pkg: tx_state_t enum {IDLE, SHIFT, DONE}; localparam MIN_CLK_DIV=2.
//  Sub-module: one Shiftreg instance (WIDTH, DIRECTION) holds the data.
//   Its sclr is tied to this block's sclr; its clrn to clrn.
//  Counters, FSM and output registers live in this module.
// TESTING
//  1 WIDTH=8, DIRECTION=0, CLK_DIV=4; send 0xA5 -> ser_data per bit 1,0,1,0,0,1,0,1.
//    ser_frame high 32 cycles; done pulse at accept+33.
//  2 DIRECTION=1, send 0x81 -> bits 1,0,0,0,0,0,0,1.
//    Sample ser_data on each ser_clk rise: 8 rises, data stable at each.
//  3 tx_valid held high with words 0x01,0x02,0x03 -> three frames, each 34 cycles apart.
//    tx_ready low between accepts; no word dropped or duplicated.
//  4 clrn low during bit 3 of 0xFF -> all outputs 0 and tx_ready=1 immediately.
//    Next word 0x0F is sent intact.
//  5 sclr low for one edge mid-word -> same as case 4, but effective at the edge.
//  6 CLK_DIV=2, WIDTH=2, send 2'b10 -> ser_clk toggles every cycle; bits 0,1; done at accept+5.

Source files
------------

// File: rtl/ser_pkg.sv
// Shared types and constants for the serial word transmitter.
`timescale 1ns/1ps
package ser_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} tx_state_t;
  localparam int unsigned MIN_CLK_DIV = 2;
endpackage

// File: rtl/ser_word_tx_shiftreg.sv
// Loadable shift register primitive; shiftout is the bit that leaves on the next shift.
`timescale 1ns/1ps
module shiftreg #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          DIRECTION = 1'b0
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             sclr,
  input  logic             load,
  input  logic             en,
  input  logic             shiftin,
  input  logic [WIDTH-1:0] data,
  output logic             shiftout
);
  logic [WIDTH-1:0] q;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      q <= '0;
    end else if (!sclr) begin
      q <= '0;
    end else if (en) begin
      if (load)           q <= data;
      else if (DIRECTION) q <= {q[WIDTH-2:0], shiftin};
      else                q <= {shiftin, q[WIDTH-1:1]};
    end
  end

  assign shiftout = DIRECTION ? q[WIDTH-1] : q[0];
endmodule

// File: rtl/ser_word_tx.sv
// Parallel-to-serial word transmitter with framed serial output.
`timescale 1ns/1ps
module ser_word_tx
  import ser_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter bit          DIRECTION = 1'b0,
  parameter int unsigned CLK_DIV   = 4
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             sclr,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic             ser_clk,
  output logic             ser_data,
  output logic             ser_frame,
  output logic             busy,
  output logic             done
);
  localparam int unsigned DW = $clog2(CLK_DIV);
  localparam int unsigned BW = $clog2(WIDTH);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

  if (CLK_DIV < MIN_CLK_DIV || (CLK_DIV % 2) != 0) begin : g_bad_div
    $error("ser_word_tx: CLK_DIV must be even and >= %0d", MIN_CLK_DIV);
  end
  if (WIDTH < 2) begin : g_bad_width
    $error("ser_word_tx: WIDTH must be >= 2");
  end

  tx_state_t     state, state_n;
  logic [DW-1:0] div_cnt, div_n;
  logic [BW-1:0] bit_cnt, bit_n;
  logic          sclk_n, frame_n;
  logic          sr_load, sr_en, sr_out;

  shiftreg #(.WIDTH(WIDTH), .DIRECTION(DIRECTION)) u_shiftreg (
    .clk     (clk),
    .clrn    (clrn),
    .sclr    (sclr),
    .load    (sr_load),
    .en      (sr_en),
    .shiftin (1'b0),
    .data    (tx_data),
    .shiftout(sr_out)
  );

  // ser_clk/ser_frame are computed one cycle ahead so they leave the block registered.
  always_comb begin
    state_n = state;
    div_n   = div_cnt;
    bit_n   = bit_cnt;
    frame_n = 1'b0;
    sclk_n  = 1'b0;
    sr_load = 1'b0;
    sr_en   = 1'b0;
    case (state)
      IDLE: begin
        if (tx_valid) begin
          sr_load = 1'b1;
          sr_en   = 1'b1;
          div_n   = '0;
          bit_n   = '0;
          frame_n = 1'b1;
          state_n = SHIFT;
        end
      end
      SHIFT: begin
        frame_n = 1'b1;
        if (div_cnt == DIV_LAST) begin
          div_n = '0;
          if (bit_cnt == BIT_LAST) begin
            state_n = DONE;
            frame_n = 1'b0;
          end else begin
            sr_en = 1'b1;
            bit_n = bit_cnt + 1'b1;
          end
        end else begin
          div_n = div_cnt + 1'b1;
        end
        sclk_n = frame_n && (div_n >= DIV_HALF);
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state     <= IDLE;
      div_cnt   <= '0;
      bit_cnt   <= '0;
      ser_clk   <= 1'b0;
      ser_frame <= 1'b0;
    end else if (!sclr) begin
      state     <= IDLE;
      div_cnt   <= '0;
      bit_cnt   <= '0;
      ser_clk   <= 1'b0;
      ser_frame <= 1'b0;
    end else begin
      state     <= state_n;
      div_cnt   <= div_n;
      bit_cnt   <= bit_n;
      ser_clk   <= sclk_n;
      ser_frame <= frame_n;
    end
  end

  assign ser_data = ser_frame & sr_out;
  assign tx_ready = (state == IDLE);
  assign busy     = (state != IDLE);
  assign done     = (state == DONE);
endmodule
